clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Parametrised, runtime-programmable integer clock divider. Generalises the fixed divide-by-4 ripple divider to any ratio 1..2^WIDTH-1 using a single synchronous counter, with no derived clocks. Produces a registered divided-clock level (clk_out) and a one-cycle period-start strobe (tick). Downstream logic uses tick as a clock enable in the clk domain; clk_out is a status/pin output, never a clock for on-chip flops. The divisor is reloaded glitch-free at period boundaries.

## Interface
- WIDTH, 8, width of divisor and counter; ratios 1..2^WIDTH-1
- DEFAULT_DIV, 4, divisor active out of reset; legal range 1..2^WIDTH-1

- clk  in  1  single clock; all state on its rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable; 0 freezes counter and clk_out, forces tick low
- div_in  in  WIDTH  requested divisor N
- div_load  in  1  one-cycle request to load div_in
- clk_out  out  1  divided level: high ceil(N/2) cycles, low floor(N/2) cycles per period
- tick  out  1  high for exactly one cycle at the start of each period
- div_act  out  WIDTH  divisor currently in effect
- pend  out  1  a loaded divisor is waiting for the next period boundary
- err  out  1  sticky: div_load seen with div_in==0

## Operation
- Registers: cnt[WIDTH], div_act, div_pend, pend, clk_out, tick, err. All outputs are flops.
- Reset (asynchronous, active-high): cnt=DEFAULT_DIV-1, div_act=DEFAULT_DIV, div_pend=0, pend=0, clk_out=0, tick=0, err=0.
- HI(N) = (N+1)>>1, computed at WIDTH+1 bits so N=2^WIDTH-1 does not overflow.
- Wrap edge: a rising edge with en=1 and cnt==div_act-1.
- Edge with en=1:
  - Wrap edge: cnt<=0, tick<=1. If pend=1: div_act<=div_pend and pend<=0. clk_out<=1 (HI≥1 for every legal N).
  - Otherwise: cnt<=cnt+1, tick<=0, clk_out<=(cnt+1 < HI(div_act)).
- Edge with en=0: cnt, clk_out, div_act, pend hold; tick<=0. A pending load stays pending.
- Load (div_load=1 at an edge):
  - div_in!=0: div_pend<=div_in, pend<=1. The last load before a wrap wins.
  - div_in==0: ignored; err<=1. err clears only on rst.
- Load at the same edge as a wrap:
  - The wrap applies the previously pending value, if any.
  - The new value becomes pending and applies at the following wrap.
- N=1: every enabled edge is a wrap edge, so tick=1 and clk_out=1 continuously.
- Even N gives exact 50% duty; odd N gives one extra high cycle.

## Timing
- First enabled edge after reset is a wrap edge: tick and clk_out rise together one cycle after en goes high.
- Period between tick pulses is exactly div_act enabled cycles; disabled cycles stretch it.
- Divisor change latency: from the edge that samples div_load to the next wrap edge, at most div_act enabled cycles.
- No runt pulse on clk_out at a divisor change: the old period always completes.
- rst asserted mid-period clears outputs immediately, without waiting for clk. After rst is released, the first enabled edge starts a fresh period at DEFAULT_DIV; pending loads and err are lost.

## Test plan
- Reset, DEFAULT_DIV=4, en=1 for 12 cycles -> clk_out 1,1,0,0 repeating; tick on cycles 1,5,9; div_act=4.
- Load 5 at cycle 2 of a period -> pend=1 until the next wrap; then div_act=5, clk_out 1,1,1,0,0, tick spacing 5, pend=0.
- Load 3 then load 7 before the same wrap, plus a load of 6 on the wrap edge itself -> wrap applies 7; 6 is pending and applies one period later.
- Load div_in=0 -> err=1, div_act and pend unchanged; err stays 1 until rst. Load 1 -> after wrap, tick and clk_out stuck high.
- en low for 3 cycles mid-period with N=4 -> cnt and clk_out frozen, tick 0; the period resumes and ends 3 cycles late.
- rst pulse mid-period while pend=1 with N=255, WIDTH=8 -> outputs zero asynchronously; restart at DEFAULT_DIV; no HI overflow at 255 (128 high, 127 low).

Source files
------------

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider with period-start tick
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_act,
    output logic             pend,
    output logic             err
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             wrap, load_ok;
    logic [WIDTH:0]   hi, cnt_inc;

    // Next-state: counter/wrap, duty level, and divisor reload held until a period boundary
    always_comb begin
        wrap       = en && (cnt_q == div_act_q - WIDTH'(1));
        load_ok    = div_load && (div_in != '0);
        hi         = ({1'b0, div_act_q} + (WIDTH+1)'(1)) >> 1;
        cnt_inc    = {1'b0, cnt_q} + (WIDTH+1)'(1);
        cnt_d      = !en ? cnt_q : wrap ? '0 : cnt_inc[WIDTH-1:0];
        tick_d     = wrap;
        clk_out_d  = !en ? clk_out_q : wrap ? 1'b1 : (cnt_inc < hi);
        div_act_d  = (wrap && pend_q) ? div_pend_q : div_act_q;
        div_pend_d = load_ok ? div_in : div_pend_q;
        pend_d     = load_ok ? 1'b1 : (wrap && pend_q) ? 1'b0 : pend_q;
        err_d      = err_q || (div_load && (div_in == '0));
    end

    // State registers with asynchronous reset to a fresh DEFAULT_DIV period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= DEF_DIV - WIDTH'(1);
            div_act_q  <= DEF_DIV;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign div_act = div_act_q;
    assign pend    = pend_q;
    assign err     = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed checks of clk_div_prog with hand-computed expectations
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst, en, div_load;
    logic [7:0] div_in;
    logic       clk_out, tick, pend, err;
    logic [7:0] div_act;
    int         n_assert = 0;
    int         n_fail   = 0;

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
        .clk_out(clk_out), .tick(tick), .div_act(div_act), .pend(pend), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full period starting at its wrap edge: high for hi cycles, tick only on the first
    task automatic period(input int n, input int hi, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_tick"}, 32'(tick), 32'(i == 0));
            chk({tag, "_clk"}, 32'(clk_out), 32'(i < hi));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = 8'd0;
        #8;
        chk("rst_clk", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_div", 32'(div_act), 4);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_err", 32'(err), 0);
        #4;
        rst = 1'b0; en = 1'b1;
        // default divide-by-4: 1,1,0,0 with tick at cycles 1,5,9
        period(4, 2, "n4a"); period(4, 2, "n4b"); period(4, 2, "n4c");
        chk("n4_div", 32'(div_act), 4);
        // load 5 at cycle 2 of a period
        step(); step();
        div_load = 1'b1; div_in = 8'd5;
        step();
        div_load = 1'b0;
        chk("ld5_pend_a", 32'(pend), 1);
        chk("ld5_div_a", 32'(div_act), 4);
        step();
        chk("ld5_pend_b", 32'(pend), 1);
        period(5, 3, "n5a");
        chk("n5_div", 32'(div_act), 5);
        chk("n5_pend", 32'(pend), 0);
        period(5, 3, "n5b");
        // load 3 then 7 before one wrap, 6 on the wrap itself
        step();
        div_load = 1'b1; div_in = 8'd3;
        step();
        div_in = 8'd7;
        step();
        div_load = 1'b0;
        step();
        chk("ld37_pend", 32'(pend), 1);
        chk("ld37_div", 32'(div_act), 5);
        step();
        div_load = 1'b1; div_in = 8'd6;
        step();
        div_load = 1'b0;
        chk("wr7_tick", 32'(tick), 1);
        chk("wr7_div", 32'(div_act), 7);
        chk("wr7_pend", 32'(pend), 1);
        for (int i = 1; i < 7; i++) begin
            step();
            chk("n7_clk", 32'(clk_out), 32'(i < 4));
            chk("n7_tick", 32'(tick), 0);
        end
        period(6, 3, "n6");
        chk("n6_div", 32'(div_act), 6);
        chk("n6_pend", 32'(pend), 0);
        // zero divisor is rejected and flagged
        div_load = 1'b1; div_in = 8'd0;
        step();
        div_load = 1'b0;
        chk("z_err", 32'(err), 1);
        chk("z_div", 32'(div_act), 6);
        chk("z_pend", 32'(pend), 0);
        chk("z_tick", 32'(tick), 1);
        // divide-by-1
        div_load = 1'b1; div_in = 8'd1;
        step();
        div_load = 1'b0;
        chk("ld1_pend", 32'(pend), 1);
        for (int i = 0; i < 4; i++) step();
        chk("ld1_err_sticky", 32'(err), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("n1_tick", 32'(tick), 1);
            chk("n1_clk", 32'(clk_out), 1);
            chk("n1_div", 32'(div_act), 1);
        end
        chk("n1_pend", 32'(pend), 0);
        // back to 4, then freeze for 3 cycles at cycle 1 of the period
        div_load = 1'b1; div_in = 8'd4;
        step();
        div_load = 1'b0;
        chk("ld4_pend", 32'(pend), 1);
        step();
        chk("ld4_tick", 32'(tick), 1);
        chk("ld4_div", 32'(div_act), 4);
        step();
        chk("fz_pre_clk", 32'(clk_out), 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fz_tick", 32'(tick), 0);
            chk("fz_clk", 32'(clk_out), 1);
        end
        en = 1'b1;
        step();
        chk("fz_c2_clk", 32'(clk_out), 0);
        chk("fz_c2_tick", 32'(tick), 0);
        step();
        chk("fz_c3_clk", 32'(clk_out), 0);
        chk("fz_c3_tick", 32'(tick), 0);
        step();
        chk("fz_wrap_tick", 32'(tick), 1);
        chk("fz_wrap_clk", 32'(clk_out), 1);
        // divide-by-255: 128 high, 127 low
        div_load = 1'b1; div_in = 8'd255;
        step();
        div_load = 1'b0;
        step(); step();
        period(255, 128, "n255");
        chk("n255_div", 32'(div_act), 255);
        // asynchronous reset mid-period with a pending load
        step();
        div_load = 1'b1; div_in = 8'd9;
        step();
        div_load = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_pend", 32'(pend), 1);
        chk("pre_rst_clk", 32'(clk_out), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_clk", 32'(clk_out), 0);
        chk("arst_pend", 32'(pend), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_div", 32'(div_act), 4);
        chk("arst_tick", 32'(tick), 0);
        #2 rst = 1'b0;
        period(4, 2, "post_a"); period(4, 2, "post_b");
        chk("post_div", 32'(div_act), 4);
        chk("post_pend", 32'(pend), 0);
        chk("post_err", 32'(err), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
